// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: expands the cipher key to round 10, then walks back to round 0.
// Optional KEY_CACHE_EN keeps the last cipher key / round-10 key pair to skip the expansion.
module aes_inv_key_schedule #(
    parameter int unsigned NR        = 10,
    parameter bit          ZERO_IDLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] ip_key,
    output logic         busy,
    output logic [127:0] op_key,
    output logic [3:0]   op_rnd,
    output logic         op_valid,
    input  logic         op_ready,
    output logic         op_last
);

    if (NR != 10) begin : g_bad_nr
        $error("aes_inv_key_schedule: only NR=10 (AES-128) is supported");
    end

    localparam logic [3:0] LastRnd = 4'(NR);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StExpand = 2'd1;
    localparam logic [1:0] StEmit   = 2'd2;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = x;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [1:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  t1, t2, t3;
    logic [31:0]  sb_word, rot_word, sub_word, mix;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] fwd_key, inv_key;
    logic         emit;

    assign w0 = key_q[31:0];
    assign w1 = key_q[63:32];
    assign w2 = key_q[95:64];
    assign w3 = key_q[127:96];

    assign t3 = w3 ^ w2;
    assign t2 = w2 ^ w1;
    assign t1 = w1 ^ w0;

    assign emit = (state_q == StEmit);

    // The S-boxes serve the forward step in EXPAND and the inverse step in EMIT
    assign sb_word  = emit ? t3 : w3;
    assign rot_word = {sb_word[7:0], sb_word[31:8]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign sub_word[8*g +: 8] = sbox(rot_word[8*g +: 8]);
    end

    assign mix = sub_word ^ {24'h0, rcon(cnt_q)};

    assign f0 = w0 ^ mix;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {f3, f2, f1, f0};
    assign inv_key = {t3, t2, t1, w0 ^ mix};

`ifdef KEY_CACHE_EN
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_rk_q, cache_rk_d;
    logic         cache_vld_q, cache_vld_d;
    logic         cache_hit;

    assign cache_hit = cache_vld_q && (ip_key == cache_key_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
`ifdef KEY_CACHE_EN
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
        cache_vld_d = cache_vld_q;
`endif
        if (abort) begin
            state_d = StIdle;
            key_d   = '0;
            cnt_d   = 4'd0;
`ifdef KEY_CACHE_EN
            cache_vld_d = 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
`ifdef KEY_CACHE_EN
                        if (cache_hit) begin
                            key_d   = cache_rk_q;
                            cnt_d   = LastRnd;
                            state_d = StEmit;
                        end else begin
                            key_d       = ip_key;
                            cnt_d       = 4'd1;
                            state_d     = StExpand;
                            cache_key_d = ip_key;
                            cache_vld_d = 1'b0;
                        end
`else
                        key_d   = ip_key;
                        cnt_d   = 4'd1;
                        state_d = StExpand;
`endif
                    end
                end
                StExpand: begin
                    key_d = fwd_key;
                    if (cnt_q == LastRnd) begin
                        state_d = StEmit;
`ifdef KEY_CACHE_EN
                        cache_rk_d  = fwd_key;
                        cache_vld_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StEmit: begin
                    if (op_ready) begin
                        if (cnt_q == 4'd0) begin
                            state_d = StIdle;
                            key_d   = '0;
                        end else begin
                            key_d = inv_key;
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    key_d   = '0;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign op_valid = emit;
    assign op_rnd   = cnt_q;
    assign op_last  = emit && (cnt_q == 4'd0);

    if (ZERO_IDLE) begin : g_zero_idle
        assign op_key = emit ? key_q : '0;
    end else begin : g_hold_idle
        logic [127:0] hold_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_q <= '0;
            end else if (emit) begin
                hold_q <= key_q;
            end
        end

        assign op_key = emit ? key_q : hold_q;
    end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule using FIPS-197 key expansion vectors.
// Build with +define+KEY_CACHE_EN to also exercise the round-10 key cache.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [127:0] ip_key;
    logic         busy;
    logic [127:0] op_key;
    logic [3:0]   op_rnd;
    logic         op_valid;
    logic         op_ready;
    logic         op_last;

    always #5 clk = ~clk;

    aes_inv_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .ip_key   (ip_key),
        .busy     (busy),
        .op_key   (op_key),
        .op_rnd   (op_rnd),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_last  (op_last)
    );

`ifdef KEY_CACHE_EN
    localparam int RepLat = 1;
`else
    localparam int RepLat = 11;
`endif

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         last;
    } beat_t;

    int           checks = 0;
    int           errors = 0;
    beat_t        tbl_b [11];
    logic [127:0] rk_b  [11];
    logic [127:0] key_a, key_b, a_r10;

    // Written FIPS byte strings put byte 0 leftmost; the port carries byte 0 in [7:0]
    function automatic logic [127:0] fips(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = s[127-8*i -: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic run(input logic [127:0] k, input bit full, input logic [127:0] exp10,
                       input bit stall, input bit poke, input int exp_lat);
        int           lat;
        int           beats;
        int           cyc;
        bit           held;
        logic [127:0] hk;
        logic [3:0]   hr;
        logic [3:0]   er;
        @(posedge clk);
        #1;
        ip_key   = k;
        start    = 1'b1;
        op_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        ip_key = ~k;
        lat    = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!op_valid && lat < 40);
        chk("latency", 128'(lat), 128'(exp_lat));
        beats = 0;
        held  = 1'b0;
        cyc   = 0;
        while (beats < 11 && cyc < 300) begin
            if (held) begin
                chk("stall key", op_key, hk);
                chk("stall rnd", 128'(op_rnd), 128'(hr));
            end
            held = 1'b0;
            if (op_valid && op_ready) begin
                er = 4'(10 - beats);
                if (full) begin
                    chk("tbl rnd", 128'(op_rnd), 128'(tbl_b[beats].rnd));
                    chk("tbl last", 128'(op_last), 128'(tbl_b[beats].last));
                    chk("tbl key", op_key, tbl_b[beats].key);
                end else begin
                    chk("rnd", 128'(op_rnd), 128'(er));
                    chk("last", 128'(op_last), 128'(er == 4'd0));
                    if (er == 4'd10) chk("key r10", op_key, exp10);
                    else if (er == 4'd0) chk("key r0", op_key, k);
                end
                beats++;
            end else if (op_valid) begin
                held = 1'b1;
                hk   = op_key;
                hr   = op_rnd;
            end else begin
                chk("valid in sequence", 128'(op_valid), 128'(1));
            end
            @(posedge clk);
            #1;
            if (stall) op_ready = 1'($urandom_range(0, 1));
            if (poke) begin
                start  = (beats == 3);
                ip_key = key_a;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        op_ready = 1'b1;
        chk("beat count", 128'(beats), 128'(11));
        chk("valid after r0", 128'(op_valid), 128'(0));
        chk("busy after r0", 128'(busy), 128'(0));
        chk("key after r0", op_key, 128'(0));
    endtask

    task automatic wait_rnd(input logic [3:0] r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(op_valid && op_rnd == r) && n < 40);
        chk("reach rnd", 128'(op_rnd), 128'(r));
    endtask

    initial begin
        rk_b[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_b[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_b[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_b[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_b[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_b[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_b[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_b[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_b[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_b[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_b[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) begin
            tbl_b[i] = '{rnd: 4'(10 - i), key: fips(rk_b[10 - i]), last: (i == 10)};
        end
        key_b = fips(rk_b[0]);
        key_a = fips(128'h000102030405060708090a0b0c0d0e0f);
        a_r10 = fips(128'h13111d7fe3944a17f307a78b4d2b30c5);

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        op_ready = 1'b1;
        ip_key   = '0;
        #12;
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset valid", 128'(op_valid), 128'(0));
        chk("reset last", 128'(op_last), 128'(0));
        chk("reset rnd", 128'(op_rnd), 128'(0));
        chk("reset key", op_key, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(key_b, 1'b1, '0, 1'b0, 1'b0, 11);
        run(key_a, 1'b0, a_r10, 1'b0, 1'b0, 11);
        run(key_b, 1'b1, '0, 1'b1, 1'b0, 11);
        run(key_b, 1'b1, '0, 1'b0, 1'b1, RepLat);

        // Abort while expanding (cnt=5)
        @(posedge clk);
        #1;
        ip_key = key_b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy in expand", 128'(busy), 128'(1));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort expand valid", 128'(op_valid), 128'(0));
        chk("abort expand busy", 128'(busy), 128'(0));
        run(key_b, 1'b1, '0, 1'b0, 1'b0, 11);

        // Abort in EMIT at rnd 4, racing a handshake
        @(posedge clk);
        #1;
        ip_key = key_a;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_rnd(4'd4);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort emit valid", 128'(op_valid), 128'(0));
        chk("abort emit busy", 128'(busy), 128'(0));
        chk("abort emit key", op_key, 128'(0));
        run(key_a, 1'b0, a_r10, 1'b0, 1'b0, 11);

        // Asynchronous reset in EMIT
        @(posedge clk);
        #1;
        ip_key = key_b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_rnd(4'd7);
        #1;
        rst = 1'b1;
        #1;
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst valid", 128'(op_valid), 128'(0));
        chk("rst last", 128'(op_last), 128'(0));
        chk("rst rnd", 128'(op_rnd), 128'(0));
        chk("rst key", op_key, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef KEY_CACHE_EN
        run(key_b, 1'b1, '0, 1'b0, 1'b0, 11);
        run(key_b, 1'b1, '0, 1'b0, 1'b0, 1);
        run(key_a, 1'b0, a_r10, 1'b0, 1'b0, 11);
        run(key_a, 1'b0, a_r10, 1'b1, 1'b0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
